loadstore_unit: RTL and testbench
=================================

LOADSTORE_UNIT -- requirements
Module: loadstore_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for wbm_ack_i before abort.
REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
- wb_clk_i  in  1  clock, single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- is_load  in  1  load request from the execution stage.
- is_store  in  1  store request from the execution stage.
- loadstore_address  in  32  byte address.
- loadstore_size  in  2  access size: 0 byte, 1 half, 2 word, 3 treated as word.
- sign_extend  in  1  sign-extend byte/half load data.
- loadstore_dest  in  6  load destination register index.
- store_data  in  32  store source register value.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone master controls.
- wbm_adr_o  out  32  word-aligned bus address.
- wbm_sel_o  out  4  byte-lane enables.
- wbm_dat_o  out  32  store data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  bus acknowledge.
- ld_we  out  1  one-cycle load writeback strobe.
- ld_idx  out  6  load writeback register index.
- ld_val  out  32  load writeback value.
- busy  out  1  pipeline stall request.
- misaligned  out  1  one-cycle misaligned-access pulse.
- bus_err  out  1  one-cycle timeout pulse.

Function
REQ-003 The block SHALL implement states IDLE, BUS and DONE.
REQ-004 A request SHALL be req = is_load|is_store, sampled only in IDLE; when is_load and is_store are both high, the block SHALL treat the request as a store.
REQ-005 A request SHALL be misaligned when it is a half with addr[0]=1, or a word (size 2/3) with addr[1:0]!=0.
REQ-006 On a misaligned request in IDLE, the block SHALL pulse misaligned for 1 cycle, go to DONE, and make no bus access.
REQ-007 On an aligned request in IDLE, the block SHALL at the next edge latch address, size, sign_extend, dest, data and direction, assert cyc/stb, and enter BUS.
REQ-008 In BUS, cyc and stb SHALL remain high and adr/sel/we/dat_o SHALL remain stable until ack or timeout.
REQ-009 wbm_adr_o SHALL be {addr[31:2],2'b00}.
REQ-010 Byte access SHALL drive sel = 1<<addr[1:0] and dat_o = {4{data[7:0]}}.
REQ-011 Half access SHALL drive sel = addr[1] ? 1100 : 0011 and dat_o = {2{data[15:0]}}.
REQ-012 Word access SHALL drive sel = 1111 and dat_o = data.
REQ-013 On wbm_ack_i in BUS, the block SHALL drop cyc/stb at the next edge and enter DONE; for a load it SHALL register ld_val and ld_idx and pulse ld_we in the DONE cycle.
REQ-014 Load data SHALL be the selected lane of wbm_dat_i shifted to bit 0, then zero-extended, or sign-extended when sign_extend=1, to 32 bits; a word load SHALL return wbm_dat_i unchanged.
REQ-015 A timeout counter SHALL clear on BUS entry and increment each BUS cycle without ack.
REQ-016 When the counter reaches TIMEOUT, the block SHALL drop cyc/stb, pulse bus_err in the DONE cycle, and suppress ld_we.
REQ-017 Ack in the same cycle as the counter reaching TIMEOUT SHALL count as ack, with no bus_err.
REQ-018 busy SHALL be combinational: (IDLE & req & !misaligned_now) | BUS.
REQ-019 busy SHALL be low in DONE, and DONE SHALL ignore req and always return to IDLE at the next edge, so the held instruction is not re-issued.
REQ-020 A store SHALL never assert ld_we.
REQ-021 Throughput SHALL be at most one access per 3 cycles (IDLE, BUS, DONE) with zero-wait ack.

Reset
REQ-022 Asserting rst at any time, including mid-BUS, SHALL immediately force IDLE and drive cyc, stb, we, ld_we, misaligned, bus_err and busy-from-BUS to 0, and adr, sel, dat_o, ld_val, ld_idx and the counter to 0.
REQ-023 After reset release, the first rising edge SHALL sample requests normally.

Verification
REQ-024 Byte load, addr 0x1003, sign_extend=1, dat_i 0x80AABBCC, ack after 2 cycles -> sel 1000, adr 0x1000, ld_val 0xFFFFFF80, ld_we 1 cycle, busy low in DONE.
REQ-025 Half store, addr 0x2002, store_data 0x1234ABCD -> sel 1100, dat_o 0xABCDABCD, we=1, no ld_we.
REQ-026 Word load, addr 0x3001 -> misaligned pulse, cyc never asserted, busy low that cycle.
REQ-027 No ack with TIMEOUT=255 -> cyc drops after 255 BUS cycles, bus_err 1 cycle, ld_we stays 0.
REQ-028 rst asserted 1 cycle into BUS -> cyc/stb 0 immediately, IDLE, no ld_we; next request completes normally.
REQ-029 Back-to-back requests held with zero-wait ack -> exactly one bus cycle per instruction, 3-cycle spacing.

Source files
------------

// File: rtl/loadstore_unit_if.sv
// Load/store request, Wishbone master and writeback signals for loadstore_unit.
// master = the load/store unit side, slave = execution stage plus bus slave side.
interface loadstore_unit_if;
  logic        is_load;
  logic        is_store;
  logic [31:0] loadstore_address;
  logic [1:0]  loadstore_size;
  logic        sign_extend;
  logic [5:0]  loadstore_dest;
  logic [31:0] store_data;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        ld_we;
  logic [5:0]  ld_idx;
  logic [31:0] ld_val;
  logic        busy;
  logic        misaligned;
  logic        bus_err;

  modport master (
    input  is_load, is_store, loadstore_address, loadstore_size, sign_extend,
           loadstore_dest, store_data, wbm_dat_i, wbm_ack_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
           ld_we, ld_idx, ld_val, busy, misaligned, bus_err
  );

  modport slave (
    output is_load, is_store, loadstore_address, loadstore_size, sign_extend,
           loadstore_dest, store_data, wbm_dat_i, wbm_ack_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
           ld_we, ld_idx, ld_val, busy, misaligned, bus_err
  );
endinterface

// File: rtl/loadstore_unit.sv
// Single-outstanding load/store unit: IDLE -> BUS -> DONE, min 3 cycles per access.
// Stalls the pipeline via combinational busy while a bus cycle is pending; aborts after TIMEOUT cycles.
module loadstore_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              rst,
  loadstore_unit_if.master  bus
);
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  localparam int            CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        r_state, w_next;
  logic [31:0]   r_adr, r_wdat, r_ld_val;
  logic [3:0]    r_sel;
  logic          r_we, r_sext, r_ld_we, r_bus_err, r_mis;
  logic [1:0]    r_size, r_lane;
  logic [5:0]    r_dest, r_ld_idx;
  logic [CW-1:0] r_cnt;

  logic          w_req, w_mis, w_start, w_ack, w_tmo, w_cyc, w_busy;
  logic [3:0]    w_sel;
  logic [31:0]   w_wdat, w_ldata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign w_req   = bus.is_load | bus.is_store;
  assign w_start = (r_state == S_IDLE) & w_req & ~w_mis;
  assign w_ack   = (r_state == S_BUS) & bus.wbm_ack_i;
  // The final BUS cycle is the one whose increment would reach TIMEOUT; ack there still wins.
  assign w_tmo   = (r_state == S_BUS) & ~bus.wbm_ack_i & (r_cnt == LAST);

  always_comb begin
    w_mis  = 1'b0;
    w_sel  = 4'b1111;
    w_wdat = bus.store_data;
    case (bus.loadstore_size)
      2'd0: begin
        w_sel  = 4'b0001 << bus.loadstore_address[1:0];
        w_wdat = {4{bus.store_data[7:0]}};
      end
      2'd1: begin
        w_mis  = bus.loadstore_address[0];
        w_sel  = bus.loadstore_address[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{bus.store_data[15:0]}};
      end
      default: w_mis = (bus.loadstore_address[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    w_byte  = bus.wbm_dat_i[{r_lane, 3'b000} +: 8];
    w_half  = r_lane[1] ? bus.wbm_dat_i[31:16] : bus.wbm_dat_i[15:0];
    w_ldata = bus.wbm_dat_i;
    case (r_size)
      2'd0:    w_ldata = {{24{r_sext & w_byte[7]}}, w_byte};
      2'd1:    w_ldata = {{16{r_sext & w_half[15]}}, w_half};
      default: w_ldata = bus.wbm_dat_i;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = w_mis ? S_DONE : S_BUS;
      S_BUS:   if (w_ack | w_tmo) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cyc  = (r_state == S_BUS);
    w_busy = w_start | (r_state == S_BUS);
  end

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      r_adr     <= '0;
      r_sel     <= '0;
      r_wdat    <= '0;
      r_we      <= 1'b0;
      r_size    <= '0;
      r_lane    <= '0;
      r_sext    <= 1'b0;
      r_dest    <= '0;
      r_cnt     <= '0;
      r_ld_we   <= 1'b0;
      r_ld_val  <= '0;
      r_ld_idx  <= '0;
      r_bus_err <= 1'b0;
      r_mis     <= 1'b0;
    end else begin
      r_ld_we   <= w_ack & ~r_we;
      r_bus_err <= w_tmo;
      r_mis     <= (r_state == S_IDLE) & w_req & w_mis;
      if (w_start) begin
        r_adr  <= {bus.loadstore_address[31:2], 2'b00};
        r_sel  <= w_sel;
        r_wdat <= w_wdat;
        r_we   <= bus.is_store;
        r_size <= bus.loadstore_size;
        r_lane <= bus.loadstore_address[1:0];
        r_sext <= bus.sign_extend;
        r_dest <= bus.loadstore_dest;
        r_cnt  <= '0;
      end else if ((r_state == S_BUS) & ~bus.wbm_ack_i) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_ack & ~r_we) begin
        r_ld_val <= w_ldata;
        r_ld_idx <= r_dest;
      end
    end
  end

  assign bus.wbm_cyc_o  = w_cyc;
  assign bus.wbm_stb_o  = w_cyc;
  assign bus.wbm_we_o   = r_we;
  assign bus.wbm_adr_o  = r_adr;
  assign bus.wbm_sel_o  = r_sel;
  assign bus.wbm_dat_o  = r_wdat;
  assign bus.ld_we      = r_ld_we;
  assign bus.ld_idx     = r_ld_idx;
  assign bus.ld_val     = r_ld_val;
  assign bus.busy       = w_busy;
  assign bus.misaligned = r_mis;
  assign bus.bus_err    = r_bus_err;
endmodule

// File: tb/tb_loadstore_unit.sv
// Randomized and directed bench for loadstore_unit against a transaction-level model.
module tb_loadstore_unit;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  loadstore_unit_if bus ();
  loadstore_unit #(.TIMEOUT(TIMEOUT)) dut (.wb_clk_i(clk), .rst(rst), .bus(bus));

  int checks, failures, exp_bus;
  int cyc_n, rises, last_rise, gap;
  logic cyc_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counts bus cycles started and the spacing between consecutive starts.
  initial begin
    cyc_n = 0; rises = 0; last_rise = 0; gap = 0; cyc_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (bus.wbm_cyc_o === 1'b1 && cyc_prev !== 1'b1) begin
        rises++;
        gap = cyc_n - last_rise;
        last_rise = cyc_n;
      end
      cyc_prev = bus.wbm_cyc_o;
    end
  end

  function automatic bit f_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] f_sel(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wdat(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] sz, input logic [31:0] a,
                                         input bit sx, input logic [31:0] rd);
    int nb, sh;
    logic [31:0] mask, v, top;
    if (sz >= 2'd2) return rd;
    nb   = (sz == 2'd0) ? 1 : 2;
    sh   = (sz == 2'd0) ? int'(a % 4) * 8 : int'((a % 4) / 2) * 16;
    mask = (32'd1 << (nb * 8)) - 32'd1;
    v    = (rd >> sh) & mask;
    top  = 32'd1 << (nb * 8 - 1);
    if (sx && (v & top) != 0) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.is_load = 1'b0; bus.is_store = 1'b0; bus.loadstore_address = '0;
    bus.loadstore_size = '0; bus.sign_extend = 1'b0; bus.loadstore_dest = '0;
    bus.store_data = '0;
  endtask

  // Entered at a negedge with the DUT in IDLE; leaves at the negedge of the following IDLE cycle.
  task automatic do_access(input bit ld, input bit st, input logic [31:0] a, input logic [1:0] sz,
                           input bit sx, input logic [5:0] dst, input logic [31:0] sd,
                           input int dly, input logic [31:0] rd);
    bit mis, acked, is_ld;
    mis   = f_mis(sz, a);
    is_ld = ld && !st;
    acked = 1'b0;
    bus.is_load = ld; bus.is_store = st; bus.loadstore_address = a;
    bus.loadstore_size = sz; bus.sign_extend = sx; bus.loadstore_dest = dst;
    bus.store_data = sd;
    #1;
    chk("req_busy", {31'd0, bus.busy}, {31'd0, !mis});
    @(negedge clk);
    if (mis) begin
      chk("mis_pulse", {31'd0, bus.misaligned}, 32'd1);
      chk("mis_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
      chk("mis_busy", {31'd0, bus.busy}, 32'd0);
      chk("mis_ldwe", {31'd0, bus.ld_we}, 32'd0);
    end else begin
      exp_bus++;
      for (int k = 0; k < TIMEOUT; k++) begin
        if (k > 0) @(negedge clk);
        chk("bus_cyc", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd3);
        chk("bus_busy", {31'd0, bus.busy}, 32'd1);
        if (k == 0) begin
          chk("bus_adr", bus.wbm_adr_o, a & ~32'd3);
          chk("bus_sel", {28'd0, bus.wbm_sel_o}, {28'd0, f_sel(sz, a)});
          chk("bus_we", {31'd0, bus.wbm_we_o}, {31'd0, st});
          if (st) chk("bus_dat", bus.wbm_dat_o, f_wdat(sz, sd));
        end
        if (k == dly) begin
          bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = rd; acked = 1'b1;
          break;
        end
        bus.wbm_ack_i = 1'b0; bus.wbm_dat_i = $urandom;
      end
      @(negedge clk);
      bus.wbm_ack_i = 1'b0;
      chk("done_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
      chk("done_busy", {31'd0, bus.busy}, 32'd0);
      chk("done_ldwe", {31'd0, bus.ld_we}, {31'd0, is_ld && acked});
      chk("done_err", {31'd0, bus.bus_err}, {31'd0, !acked});
      if (is_ld && acked) begin
        chk("ld_val", bus.ld_val, f_load(sz, a, sx, rd));
        chk("ld_idx", {26'd0, bus.ld_idx}, {26'd0, dst});
      end
    end
    @(negedge clk);
    chk("idle_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    chk("idle_pulses", {29'd0, bus.ld_we, bus.bus_err, bus.misaligned}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, rd, sd;
    logic [1:0] sz, op;
    checks = 0; failures = 0; exp_bus = 0;
    rst = 1'b1;
    idle_inputs();
    bus.wbm_ack_i = 1'b0; bus.wbm_dat_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {26'd0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.ld_we,
                    bus.misaligned, bus.bus_err}, 32'd0);
    chk("rst_adr", bus.wbm_adr_o, 32'd0);
    chk("rst_sel", {28'd0, bus.wbm_sel_o}, 32'd0);
    chk("rst_dat", bus.wbm_dat_o, 32'd0);
    chk("rst_ldval", bus.ld_val, 32'd0);
    chk("rst_ldidx", {26'd0, bus.ld_idx}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_access(1, 0, 32'h0000_1003, 2'd0, 1, 6'd5, 32'd0, 2, 32'h80AA_BBCC);
    do_access(0, 1, 32'h0000_2002, 2'd1, 0, 6'd0, 32'h1234_ABCD, 0, 32'd0);
    do_access(1, 0, 32'h0000_3001, 2'd2, 0, 6'd9, 32'd0, 0, 32'd0);
    chk("mis_no_bus", rises, exp_bus);
    do_access(1, 1, 32'h0000_0104, 2'd3, 0, 6'd4, 32'hCAFE_F00D, 1, 32'h1111_2222);
    do_access(1, 0, 32'h0000_0202, 2'd1, 1, 6'd12, 32'd0, 0, 32'h8001_7FFF);
    do_access(1, 0, 32'h0000_0040, 2'd2, 0, 6'd7, 32'd0, 1000, 32'h5555_5555);
    do_access(1, 0, 32'h0000_0044, 2'd2, 0, 6'd8, 32'd0, TIMEOUT - 1, 32'hDEAD_BEEF);

    // Reset one cycle into BUS, then a normal access.
    bus.is_load = 1'b1; bus.loadstore_address = 32'h500; bus.loadstore_size = 2'd2;
    bus.loadstore_dest = 6'd3;
    @(negedge clk);
    exp_bus++;
    chk("rst_bus0", {31'd0, bus.wbm_cyc_o}, 32'd1);
    @(negedge clk);
    chk("rst_bus1", {31'd0, bus.wbm_cyc_o}, 32'd1);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {29'd0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.busy}, 32'd0);
    chk("rst_mid_adr", bus.wbm_adr_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after", {30'd0, bus.ld_we, bus.wbm_cyc_o}, 32'd0);
    do_access(1, 0, 32'h0000_0602, 2'd0, 0, 6'd21, 32'd0, 0, 32'h00F1_0000);

    for (int i = 0; i < 4; i++) begin
      do_access(i[0], !i[0], 32'h700 + 32'(i * 4), 2'd2, 0, 6'(i), $urandom, 0, $urandom);
      if (i > 0) chk("b2b_gap", 32'(gap), 32'd3);
    end

    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'd3;
      op = 2'($urandom_range(1, 3));
      rd = $urandom; sd = $urandom;
      do_access(op[0], op[1], a, sz, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                sd, $urandom_range(0, 4), rd);
    end

    chk("bus_cycles", rises, exp_bus);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
